// File: rtl/control_unit.sv
// ============================================================================
//  Module      : control_unit
//  Description : Multicycle Moore control FSM for the MIPS-subset datapath.
//                Sequences fetch, decode, execute, memory and write-back
//                steps and drives every write strobe and mux select.
//                Optional macro CTRL_OVF_EXC_EN: when defined, an ULA
//                overflow in add/sub/addi raises an exception (cause 1)
//                instead of writing back the wrapped result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit #(
    parameter int          MEM_WAIT   = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC,
    parameter logic [31:0] SP_INIT    = 32'd227
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Overflow,
    input  logic       Igual,
    output logic       PC_write,
    output logic       A_write,
    output logic       B_write,
    output logic       ALUOut_write,
    output logic       MDR_write,
    output logic       IRWrite,
    output logic       EPC_write,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IorD,
    output logic       seletor_ulaA,
    output logic [1:0] seletor_ulaB,
    output logic [2:0] Seletor,
    output logic [2:0] ShiftOP,
    output logic [1:0] RegDst,
    output logic [2:0] MemToReg,
    output logic [2:0] PCSource,
    output logic       exc_cause
);

    // Configuration sanity: memory needs at least one wait cycle, the handler
    // address must be word aligned, and the reset stack must not sit on it.
    if (MEM_WAIT < 1 || EXC_VECTOR[1:0] != 2'b00 || SP_INIT == EXC_VECTOR) begin : g_bad_config
        $error("control_unit: invalid MEM_WAIT / EXC_VECTOR / SP_INIT");
    end

    localparam int             CW       = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_WAIT);

    localparam logic [4:0] ST_RESET   = 5'd0;
    localparam logic [4:0] ST_FETCH   = 5'd1;
    localparam logic [4:0] ST_DECODE  = 5'd2;
    localparam logic [4:0] ST_EXEC_R  = 5'd3;
    localparam logic [4:0] ST_WB_R    = 5'd4;
    localparam logic [4:0] ST_SH_LOAD = 5'd5;
    localparam logic [4:0] ST_SH_OP   = 5'd6;
    localparam logic [4:0] ST_WB_SH   = 5'd7;
    localparam logic [4:0] ST_JR      = 5'd8;
    localparam logic [4:0] ST_EXEC_I  = 5'd9;
    localparam logic [4:0] ST_WB_I    = 5'd10;
    localparam logic [4:0] ST_ADDR    = 5'd11;
    localparam logic [4:0] ST_MEM_RD  = 5'd12;
    localparam logic [4:0] ST_WB_LW   = 5'd13;
    localparam logic [4:0] ST_MEM_WR  = 5'd14;
    localparam logic [4:0] ST_BR      = 5'd15;
    localparam logic [4:0] ST_JMP     = 5'd16;
    localparam logic [4:0] ST_EXC     = 5'd17;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    logic [4:0]    state;
    logic [4:0]    next_state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    logic          cause_next;
    logic          wait_done;

    assign wait_done = (wait_cnt == CNT_LAST);

    // State, wait counter and exception cause registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RESET;
            wait_cnt  <= '0;
            exc_cause <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= wait_cnt_next;
            exc_cause <= cause_next;
        end
    end

    // Next-state logic; opcode/funct come from IR, which is stable after fetch.
    always_comb begin
        next_state    = state;
        cause_next    = exc_cause;
        wait_cnt_next = '0;
        case (state)
            ST_RESET: next_state = ST_FETCH;
            ST_FETCH: begin
                if (wait_done) next_state = ST_DECODE;
                else           wait_cnt_next = wait_cnt + 1'b1;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND: next_state = ST_EXEC_R;
                            FN_SLL, FN_SRL:         next_state = ST_SH_LOAD;
                            FN_JR:                  next_state = ST_JR;
                            default: begin
                                next_state = ST_EXC;
                                cause_next = 1'b0;
                            end
                        endcase
                    end
                    OP_ADDI:        next_state = ST_EXEC_I;
                    OP_LW, OP_SW:   next_state = ST_ADDR;
                    OP_BEQ, OP_BNE: next_state = ST_BR;
                    OP_J:           next_state = ST_JMP;
                    default: begin
                        next_state = ST_EXC;
                        cause_next = 1'b0;
                    end
                endcase
            end
`ifdef CTRL_OVF_EXC_EN
            ST_EXEC_R: begin
                if (Overflow && funct != FN_AND) begin
                    next_state = ST_EXC;
                    cause_next = 1'b1;
                end else begin
                    next_state = ST_WB_R;
                end
            end
            ST_EXEC_I: begin
                if (Overflow) begin
                    next_state = ST_EXC;
                    cause_next = 1'b1;
                end else begin
                    next_state = ST_WB_I;
                end
            end
`else
            ST_EXEC_R: next_state = ST_WB_R;
            ST_EXEC_I: next_state = ST_WB_I;
`endif
            ST_SH_LOAD: next_state = ST_SH_OP;
            ST_SH_OP:   next_state = ST_WB_SH;
            ST_ADDR:    next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (wait_done) next_state = ST_WB_LW;
                else           wait_cnt_next = wait_cnt + 1'b1;
            end
            default:    next_state = ST_FETCH;
        endcase
    end

`ifndef CTRL_OVF_EXC_EN
    // Overflow has no effect when overflow exceptions are disabled.
    logic unused_overflow;
    assign unused_overflow = Overflow;
`endif

    // Moore output decode; only the branch strobe looks at Igual.
    always_comb begin
        PC_write     = 1'b0;
        A_write      = 1'b0;
        B_write      = 1'b0;
        ALUOut_write = 1'b0;
        MDR_write    = 1'b0;
        IRWrite      = 1'b0;
        EPC_write    = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        seletor_ulaA = 1'b0;
        seletor_ulaB = 2'b00;
        Seletor      = 3'b000;
        ShiftOP      = 3'b000;
        RegDst       = 2'b00;
        MemToReg     = 3'b000;
        PCSource     = 3'b000;
        case (state)
            ST_RESET: begin
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemToReg = 3'b011;
            end
            ST_FETCH: begin
                seletor_ulaB = 2'b01;
                Seletor      = 3'b001;
                if (wait_done) begin
                    IRWrite  = 1'b1;
                    PC_write = 1'b1;
                end
            end
            ST_DECODE: begin
                A_write      = 1'b1;
                B_write      = 1'b1;
                ALUOut_write = 1'b1;
                seletor_ulaB = 2'b11;
                Seletor      = 3'b001;
            end
            ST_EXEC_R: begin
                seletor_ulaA = 1'b1;
                ALUOut_write = 1'b1;
                case (funct)
                    FN_SUB:  Seletor = 3'b010;
                    FN_AND:  Seletor = 3'b011;
                    default: Seletor = 3'b001;
                endcase
            end
            ST_WB_R: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            ST_SH_LOAD: ShiftOP = 3'b001;
            ST_SH_OP:   ShiftOP = (funct == FN_SRL) ? 3'b011 : 3'b010;
            ST_WB_SH: begin
                RegDst   = 2'b01;
                MemToReg = 3'b010;
                RegWrite = 1'b1;
            end
            ST_JR: begin
                PC_write = 1'b1;
                PCSource = 3'b011;
            end
            ST_EXEC_I, ST_ADDR: begin
                seletor_ulaA = 1'b1;
                seletor_ulaB = 2'b10;
                Seletor      = 3'b001;
                ALUOut_write = 1'b1;
            end
            ST_WB_I: RegWrite = 1'b1;
            ST_MEM_RD: begin
                IorD      = 1'b1;
                MDR_write = wait_done;
            end
            ST_WB_LW: begin
                MemToReg = 3'b001;
                RegWrite = 1'b1;
            end
            ST_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_BR: begin
                seletor_ulaA = 1'b1;
                Seletor      = 3'b111;
                PCSource     = 3'b001;
                PC_write     = (opcode == OP_BEQ) ? Igual : ~Igual;
            end
            ST_JMP: begin
                PC_write = 1'b1;
                PCSource = 3'b010;
            end
            ST_EXC: begin
                seletor_ulaB = 2'b01;
                Seletor      = 3'b010;
                EPC_write    = 1'b1;
                PC_write     = 1'b1;
                PCSource     = 3'b100;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
